wb_unit: RTL and testbench
==========================

Name: wb_unit

Overview:
- Writeback unit that sits between the result producers (ALU and load path) and the write port of reg_file.
- Buffers results from the two sources and arbitrates them onto the single register-file write port (write_sig/write_reg/write_val).
- Keeps a per-register pending-write scoreboard so decode can stall on read-after-write hazards.

Parameters:
- DEPTH, 4, entries per source FIFO (power of two, >=2)
- XLEN, 64, result data width

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-low (reset==0 resets)
- issue_valid  input  1  decode issues an instruction that will write issue_rd
- issue_rd  input  5  destination register of issuing instruction
- issue_ready  output  1  scoreboard can accept issue for issue_rd
- alu_valid  input  1  ALU result offered
- alu_rd  input  5  ALU destination register
- alu_val  input  XLEN  ALU result
- alu_ready  output  1  ALU FIFO not full
- mem_valid  input  1  load result offered
- mem_rd  input  5  load destination register
- mem_val  input  XLEN  load data
- mem_ready  output  1  load FIFO not full
- write_sig  output  1  register-file write enable
- write_reg  output  5  register-file write address
- write_val  output  XLEN  register-file write data
- busy_mask  output  32  bit i = register i has pending write(s)
- sb_err  output  1  sticky scoreboard underflow/overflow flag

Behaviour:
- Reset (async, active-low): FIFOs emptied, all counters 0, RR pointer favours mem; write_sig=0, write_reg=0, write_val=0, busy_mask=0, sb_err=0, alu_ready=mem_ready=1. A reset asserted mid-operation discards all buffered results with no write.
- Source handshake: a transfer occurs on the posedge where valid&&ready. ready depends only on own FIFO fullness (registered count), never on valid. FIFO full -> ready=0; a push is ignored if ready=0.
- Simultaneous push and pop on a full FIFO: the pop frees a slot only from the next cycle, so ready stays 0 that cycle.
- Arbitration, evaluated each cycle on FIFO heads:
  - Neither FIFO empty -> grant the source opposite to the last grant (round robin).
  - Only one FIFO non-empty -> grant it.
  - Both empty -> no grant.
  - The granted head is popped at the posedge and its rd/val are registered into write_reg/write_val, with write_sig=1 for exactly that next cycle.
- Latency: a result pushed at edge N into an empty FIFO, with no contention, appears on write_sig at cycle N+1 to N+2 (pop at edge N+1, write_sig high after it). Sustained throughput is 1 write/cycle.
- write_reg/write_val hold their last value when write_sig=0.
- rd==0: the entry is popped and consumes its grant slot, but write_sig stays 0 and the scoreboard is untouched.
- Scoreboard: 2-bit saturating counter per register 1..31; register 0 counter is always 0.
  - Increment on issue_valid && issue_ready && issue_rd!=0.
  - Decrement on the cycle write_sig=1 for that write_reg.
  - Same-register increment and decrement in one cycle -> net unchanged.
  - busy_mask[i] = (cnt[i]!=0), registered; busy_mask[0]=0.
  - issue_ready = (cnt[issue_rd]!=3) || (decrement of issue_rd this cycle); it is combinational from issue_rd.
  - A retire when cnt==0 leaves cnt=0 and sets sb_err. An issue while issue_ready=0 is ignored and sets sb_err. sb_err clears only on reset.
- Ordering: FIFO order is preserved within each source. No ordering is guaranteed across sources; decode must use busy_mask for WAW hazards.

Test Plan:
- Reset mid-traffic: fill ALU FIFO with 3 entries, drop reset low -> write_sig=0 immediately, busy_mask=0, alu_ready=1; after release no stale writes occur.
- Single ALU result: issue rd=5; then alu_valid rd=5 val=0xDEAD_BEEF -> busy_mask[5]=1 until the write cycle. write_sig=1, write_reg=5, write_val=0xDEADBEEF in one cycle, then busy_mask[5]=0.
- Contention: both sources push every cycle (alu rd=1..4, mem rd=11..14) -> writes alternate mem,alu,mem,alu starting with mem. All 8 writes land, and FIFO order is preserved per source.
- Backpressure: push DEPTH+1 ALU results while mem traffic keeps winning alternate slots -> alu_ready=0 after 4 buffered entries. The extra push is dropped, and no value is lost or duplicated for accepted entries.
- x0 and saturation: result rd=0 val=0x1 -> no write_sig, entry is consumed. Issue rd=7 three times -> issue_ready=0. A fourth issue sets sb_err=1 with cnt[7] staying 3.
- Same-cycle issue/retire: cnt[9]=1, retire rd=9 with a new issue rd=9 in the same cycle -> cnt[9] stays 1, busy_mask[9] stays 1, sb_err=0.

Source files
------------

// File: rtl/wb_unit.sv
// Writeback unit: buffers ALU and load results, round-robins them onto the single
// register-file write port, and tracks pending writes per register for hazard stalls.
module wb_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_val,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_val,
    output logic            mem_ready,
    output logic            write_sig,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] write_val,
    output logic [31:0]     busy_mask,
    output logic            sb_err
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned NSRC = 2;
    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = 5;

    typedef struct packed {
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] val;
    } entry_t;

    entry_t                      buf_q [NSRC][DEPTH];
    entry_t                      buf_d [NSRC][DEPTH];
    logic [NSRC-1:0][PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [NSRC-1:0][CW-1:0]     cnt_q, cnt_d;
    logic                        last_alu_q, last_alu_d;
    logic                        write_sig_q, write_sig_d;
    logic [RW-1:0]               write_reg_q, write_reg_d;
    logic [XLEN-1:0]             write_val_q, write_val_d;
    logic [NREG-1:0][1:0]        sb_q, sb_d;
    logic [NREG-1:0]             busy_q, busy_d;
    logic                        err_q, err_d;
    logic [NSRC-1:0]             src_valid, src_ready, push, nonempty, grant;
    entry_t                      src_in [NSRC];
    entry_t                      head;
    logic                        issue_inc;

    assign src_valid = {mem_valid, alu_valid};
    assign src_in[0] = '{rd: alu_rd, val: alu_val};
    assign src_in[1] = '{rd: mem_rd, val: mem_val};

    assign alu_ready   = src_ready[0];
    assign mem_ready   = src_ready[1];
    assign write_sig   = write_sig_q;
    assign write_reg   = write_reg_q;
    assign write_val   = write_val_q;
    assign busy_mask   = busy_q;
    assign sb_err      = err_q;
    // A retiring write to issue_rd frees a counter slot in the same cycle.
    assign issue_ready = (sb_q[issue_rd] != 2'd3) || (write_sig_q && (write_reg_q == issue_rd));

    // FIFO bookkeeping, round-robin arbitration and write-port staging
    always_comb begin
        src_ready   = '0;
        nonempty    = '0;
        push        = '0;
        grant       = '0;
        head        = '0;
        last_alu_d  = last_alu_q;
        buf_d       = buf_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        for (int unsigned s = 0; s < NSRC; s++) begin
            src_ready[s] = (cnt_q[s] != CW'(DEPTH));
            nonempty[s]  = (cnt_q[s] != '0);
            push[s]      = src_valid[s] && src_ready[s];
        end
        if (&nonempty) begin
            grant = last_alu_q ? 2'b10 : 2'b01;
        end else begin
            grant = nonempty;
        end
        if (grant[1]) begin
            head       = buf_q[1][head_q[1]];
            last_alu_d = 1'b0;
        end else if (grant[0]) begin
            head       = buf_q[0][head_q[0]];
            last_alu_d = 1'b1;
        end
        for (int unsigned s = 0; s < NSRC; s++) begin
            head_d[s] = head_q[s] + PW'(grant[s]);
            tail_d[s] = tail_q[s] + PW'(push[s]);
            cnt_d[s]  = cnt_q[s] + CW'(push[s]) - CW'(grant[s]);
            if (push[s]) begin
                buf_d[s][tail_q[s]] = src_in[s];
            end
        end
        // x0 results burn their grant slot without touching the register file
        write_sig_d = (|grant) && (head.rd != '0);
        write_reg_d = write_sig_d ? head.rd  : write_reg_q;
        write_val_d = write_sig_d ? head.val : write_val_q;
    end

    // Pending-write scoreboard: 2-bit saturating count per architectural register
    always_comb begin
        sb_d      = sb_q;
        err_d     = err_q;
        busy_d    = '0;
        issue_inc = issue_valid && issue_ready && (issue_rd != '0);
        if (issue_valid && !issue_ready) begin
            err_d = 1'b1;
        end
        if (write_sig_q && (sb_q[write_reg_q] == 2'd0)) begin
            err_d = 1'b1;
        end
        for (int unsigned r = 1; r < NREG; r++) begin
            if (issue_inc && (issue_rd == RW'(r)) && !(write_sig_q && (write_reg_q == RW'(r)))) begin
                sb_d[r] = sb_q[r] + 2'd1;
            end else if (!(issue_inc && (issue_rd == RW'(r))) && write_sig_q
                         && (write_reg_q == RW'(r)) && (sb_q[r] != 2'd0)) begin
                sb_d[r] = sb_q[r] - 2'd1;
            end
        end
        sb_d[0] = 2'd0;
        for (int unsigned r = 0; r < NREG; r++) begin
            busy_d[r] = (sb_d[r] != 2'd0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            last_alu_q  <= 1'b1;
            write_sig_q <= 1'b0;
            write_reg_q <= '0;
            write_val_q <= '0;
            sb_q        <= '0;
            busy_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            last_alu_q  <= last_alu_d;
            write_sig_q <= write_sig_d;
            write_reg_q <= write_reg_d;
            write_val_q <= write_val_d;
            sb_q        <= sb_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    // Payload storage needs no reset: occupancy counters gate every read
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: table-driven scoreboard/writeback vectors plus
// hand-written sequences for contention, backpressure and reset corner cases.
module tb_wb_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_val;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [63:0] mem_val;
    logic        mem_ready;
    logic        write_sig;
    logic [4:0]  write_reg;
    logic [63:0] write_val;
    logic [31:0] busy_mask;
    logic        sb_err;

    wb_unit #(.DEPTH(4), .XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_val(alu_val), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_val(mem_val), .mem_ready(mem_ready),
        .write_sig(write_sig), .write_reg(write_reg), .write_val(write_val),
        .busy_mask(busy_mask), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] val;
    } wr_t;

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic        av;
        logic [4:0]  ard;
        logic [63:0] aval;
        logic        exp_ir;
        logic        exp_ws;
        logic [4:0]  exp_wr;
        logic [63:0] exp_wv;
        logic [31:0] exp_busy;
        logic        exp_err;
    } vec_t;

    wr_t wq[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    always @(negedge clk) begin
        if (write_sig) wq.push_back('{rd: write_reg, val: write_val});
    end

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = 5'd0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_val = 64'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_val = 64'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    localparam logic [63:0] DB = 64'hDEAD_BEEF;
    vec_t tv [15];
    wr_t  exp_q[$];
    wr_t  aq[$];
    wr_t  mq[$];

    initial begin
        // iv ird av ard aval | ir ws wr wv busy err
        tv[0]  = '{1'b1, 5'd5, 1'b0, 5'd0, 64'd0,  1'b1, 1'b0, 5'd0, 64'd0,  32'h20, 1'b0};
        tv[1]  = '{1'b0, 5'd0, 1'b1, 5'd5, DB,     1'b1, 1'b0, 5'd0, 64'd0,  32'h20, 1'b0};
        tv[2]  = '{1'b0, 5'd0, 1'b0, 5'd0, 64'd0,  1'b1, 1'b1, 5'd5, DB,     32'h20, 1'b0};
        tv[3]  = '{1'b0, 5'd0, 1'b0, 5'd0, 64'd0,  1'b1, 1'b0, 5'd5, DB,     32'h0,  1'b0};
        tv[4]  = '{1'b0, 5'd0, 1'b1, 5'd0, 64'd1,  1'b1, 1'b0, 5'd5, DB,     32'h0,  1'b0};
        tv[5]  = '{1'b0, 5'd0, 1'b0, 5'd0, 64'd0,  1'b1, 1'b0, 5'd5, DB,     32'h0,  1'b0};
        tv[6]  = '{1'b0, 5'd0, 1'b0, 5'd0, 64'd0,  1'b1, 1'b0, 5'd5, DB,     32'h0,  1'b0};
        tv[7]  = '{1'b1, 5'd7, 1'b0, 5'd0, 64'd0,  1'b1, 1'b0, 5'd5, DB,     32'h80, 1'b0};
        tv[8]  = '{1'b1, 5'd7, 1'b0, 5'd0, 64'd0,  1'b1, 1'b0, 5'd5, DB,     32'h80, 1'b0};
        tv[9]  = '{1'b1, 5'd7, 1'b0, 5'd0, 64'd0,  1'b1, 1'b0, 5'd5, DB,     32'h80, 1'b0};
        tv[10] = '{1'b1, 5'd7, 1'b0, 5'd0, 64'd0,  1'b0, 1'b0, 5'd5, DB,     32'h80, 1'b1};
        tv[11] = '{1'b0, 5'd7, 1'b1, 5'd7, 64'h77, 1'b0, 1'b0, 5'd5, DB,     32'h80, 1'b1};
        tv[12] = '{1'b0, 5'd7, 1'b0, 5'd0, 64'd0,  1'b0, 1'b1, 5'd7, 64'h77, 32'h80, 1'b1};
        tv[13] = '{1'b0, 5'd7, 1'b0, 5'd0, 64'd0,  1'b1, 1'b0, 5'd7, 64'h77, 32'h80, 1'b1};
        tv[14] = '{1'b0, 5'd7, 1'b0, 5'd0, 64'd0,  1'b1, 1'b0, 5'd7, 64'h77, 32'h80, 1'b1};

        reset = 1'b0;
        idle_inputs();
        #12;
        chk("rst_write_sig", 69'(write_sig), 69'(1'b0));
        chk("rst_write_reg", 69'(write_reg), 69'(5'd0));
        chk("rst_write_val", 69'(write_val), 69'(64'd0));
        chk("rst_busy_mask", 69'(busy_mask), 69'(32'd0));
        chk("rst_sb_err", 69'(sb_err), 69'(1'b0));
        chk("rst_alu_ready", 69'(alu_ready), 69'(1'b1));
        chk("rst_mem_ready", 69'(mem_ready), 69'(1'b1));
        chk("rst_issue_ready", 69'(issue_ready), 69'(1'b1));
        @(negedge clk);
        reset = 1'b1;

        // Single result, x0 consumption, saturation and sticky overflow
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            issue_valid = tv[i].iv; issue_rd = tv[i].ird;
            alu_valid = tv[i].av; alu_rd = tv[i].ard; alu_val = tv[i].aval;
            #1 chk($sformatf("v%0d_issue_ready", i), 69'(issue_ready), 69'(tv[i].exp_ir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_write_sig", i), 69'(write_sig), 69'(tv[i].exp_ws));
            chk($sformatf("v%0d_write_reg", i), 69'(write_reg), 69'(tv[i].exp_wr));
            chk($sformatf("v%0d_write_val", i), 69'(write_val), 69'(tv[i].exp_wv));
            chk($sformatf("v%0d_busy_mask", i), 69'(busy_mask), 69'(tv[i].exp_busy));
            chk($sformatf("v%0d_sb_err", i), 69'(sb_err), 69'(tv[i].exp_err));
        end

        // Same-cycle issue and retire of rd=9
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd9;
        @(negedge clk);
        issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd9; alu_val = 64'h9;
        @(negedge clk);
        alu_valid = 1'b0;
        @(negedge clk);
        chk("same_ws", 69'(write_sig), 69'(1'b1));
        chk("same_wr", 69'(write_reg), 69'(5'd9));
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1 chk("same_issue_ready", 69'(issue_ready), 69'(1'b1));
        @(posedge clk);
        #1;
        chk("same_busy9", 69'(busy_mask[9]), 69'(1'b1));
        chk("same_sb_err", 69'(sb_err), 69'(1'b0));
        @(negedge clk);
        issue_valid = 1'b0;
        @(posedge clk);
        #1 chk("same_busy9_hold", 69'(busy_mask[9]), 69'(1'b1));

        // Contention: mem wins first, then strict alternation
        do_reset();
        wq.delete();
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{rd: 5'(11 + k), val: 64'h200 + 64'(k)});
            exp_q.push_back('{rd: 5'(1 + k), val: 64'h100 + 64'(k)});
        end
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(1 + k); alu_val = 64'h100 + 64'(k);
            mem_valid = 1'b1; mem_rd = 5'(11 + k); mem_val = 64'h200 + 64'(k);
            @(negedge clk);
        end
        idle_inputs();
        repeat (12) @(negedge clk);
        chk("cont_count", 69'(wq.size()), 69'(8));
        for (int i = 0; i < 8 && i < wq.size(); i++)
            chk($sformatf("cont_w%0d", i), 69'(wq[i]), 69'(exp_q[i]));

        // Backpressure: ALU FIFO fills while mem takes alternate slots
        do_reset();
        wq.delete();
        for (int k = 0; k < 7; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(1 + k); alu_val = 64'h300 + 64'(k);
            mem_valid = (k < 6); mem_rd = 5'(20 + k); mem_val = 64'h400 + 64'(k);
            #1;
            if (k == 5) chk("bp_ready_before_full", 69'(alu_ready), 69'(1'b1));
            if (k == 6) chk("bp_ready_full", 69'(alu_ready), 69'(1'b0));
            @(negedge clk);
        end
        idle_inputs();
        #1 chk("bp_ready_after_pop", 69'(alu_ready), 69'(1'b1));
        repeat (15) @(negedge clk);
        chk("bp_total", 69'(wq.size()), 69'(12));
        aq.delete();
        mq.delete();
        foreach (wq[i]) begin
            if (wq[i].rd >= 5'd20) mq.push_back(wq[i]);
            else aq.push_back(wq[i]);
        end
        chk("bp_alu_count", 69'(aq.size()), 69'(6));
        chk("bp_mem_count", 69'(mq.size()), 69'(6));
        for (int i = 0; i < 6 && i < aq.size(); i++)
            chk($sformatf("bp_alu%0d", i), 69'(aq[i].val), 69'(64'h300 + 64'(i)));
        for (int i = 0; i < 6 && i < mq.size(); i++)
            chk($sformatf("bp_mem%0d", i), 69'(mq[i].val), 69'(64'h400 + 64'(i)));

        // Reset asserted with results in flight
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd30;
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(1 + k); alu_val = 64'h500 + 64'(k);
            @(negedge clk);
            issue_valid = 1'b0;
        end
        alu_valid = 1'b0;
        chk("mid_pre_ws", 69'(write_sig), 69'(1'b1));
        chk("mid_pre_busy", 69'(busy_mask), 69'(32'h4000_0000));
        reset = 1'b0;
        #1;
        chk("mid_ws", 69'(write_sig), 69'(1'b0));
        chk("mid_busy", 69'(busy_mask), 69'(32'd0));
        chk("mid_alu_ready", 69'(alu_ready), 69'(1'b1));
        chk("mid_write_reg", 69'(write_reg), 69'(5'd0));
        repeat (2) @(negedge clk);
        wq.delete();
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_no_stale", 69'(wq.size()), 69'(0));
        chk("mid_sb_err", 69'(sb_err), 69'(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
